rect_compositor: RTL
====================

Name: rect_compositor

Overview:
- Pixel-colour source for the HDMI path. Sits between the video timing generator and the three TMDS encoders.
- Holds a bank of N_RECTS filled rectangles written over a valid/ready command port, and composites them over a background colour.
- Emits sync, draw_area and RGB, pipeline-aligned, to the encoders.
- Rectangle updates are double-buffered and take effect only at frame start, so there is no tearing.

Parameters:
- N_RECTS, 8: number of rectangle slots; slot 0 has highest priority.
- H_PIXELS, 800: active pixels per line.
- V_PIXELS, 600: active lines per frame.
- COORD_W, 10: width of x/y coordinates.

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when valid&&ready.
- cmd_index  in  $clog2(N_RECTS)  target slot.
- cmd_x0, cmd_y0, cmd_x1, cmd_y1  in  COORD_W each  inclusive corners.
- cmd_color  in  24  {R,G,B}.
- cmd_enable  in  1  slot visible.
- bg_color  in  24  background {R,G,B}, sampled every cycle.
- in_hsync, in_vsync, in_draw_area  in  1 each  from the timing generator.
- out_hsync, out_vsync, out_draw_area  out  1 each  delayed copies.
- red, green, blue  out  8 each  pixel colour.

Behaviour:
- Reset: clocking and reset are decided as follows. There is one clock, clk. Reset rst_n is asynchronous and active-low.
  - All outputs reset to 0. cmd_ready resets to 0 and rises the first cycle after rst_n deasserts.
  - All shadow and active slots reset to disabled. x=0, y=0.
  - Reset mid-frame discards pending commands and the active set.
- Command port:
  - A command is accepted when cmd_valid && cmd_ready. It writes the shadow slot cmd_index.
  - cmd_ready is 1 except during the commit cycle, when it is 0.
  - Multiple writes to the same slot before a commit: the last one wins.
  - cmd_index >= N_RECTS: the command is accepted and ignored.
- Commit: on the cycle after a rising edge of in_vsync, all shadow slots are copied to the active slots.
  - A write accepted in the cycle before the commit is included in it.
- Position counters (stage 0, registered):
  - While in_draw_area=1, x increments each cycle and saturates at H_PIXELS-1.
  - On a falling edge of in_draw_area: x←0 and y←y+1, saturating at V_PIXELS-1.
  - On a rising edge of in_vsync: y←0 and x←0.
- Pipeline, 2 cycles:
  - Stage 1 registers hit[i] = enable_i && x0_i<=x<=x1_i && y0_i<=y<=y1_i. All comparisons are unsigned.
  - A slot with x0>x1 or y0>y1 never hits.
  - Stage 2 takes the lowest-index hit's colour, or bg_color if there is no hit. It forces RGB to 0 when draw_area is 0 at that stage.
  - in_hsync, in_vsync and in_draw_area are delayed through a 2-deep shift so the out_* signals align with RGB.
  - Total latency from in_* to out_*/RGB is exactly 2 cycles.
- Coordinates at or beyond H_PIXELS/V_PIXELS are legal and simply clip.

Optional Feature:
- Macro: RECT_OUTLINE_EN.
- When defined:
  - An extra input port cmd_outline (1 bit) is stored per slot.
  - An outlined slot hits only on its 1-pixel border (x==x0 || x==x1 || y==y0 || y==y1, inside the box). The interior falls through to lower-priority slots or the background.
- When undefined: the port is absent and all slots are filled.
- Latency is 2 cycles in both builds.

Test Plan:
- Reset mid-frame:
  - Stimulus: assert rst_n=0 at an arbitrary cycle.
  - Required response: all outputs are 0 immediately (asynchronously). cmd_ready=0, then 1 one cycle after release. The next frame shows only bg_color=24'h102030.
- Single rectangle:
  - Stimulus: slot 0 = (10,20)-(19,29), color 24'hFF0000, enabled, committed at vsync.
  - Required response: pixel (10,20) and (19,29) are FF/00/00. Pixel (9,20) and (20,29) are bg. Output lags in_draw_area by exactly 2 cycles.
- Priority:
  - Stimulus: slot 3 = (0,0)-(799,599) green; slot 1 = (100,100)-(199,199) blue.
  - Required response: (150,150) is blue, (50,50) is green. After slot 1 is disabled and the next vsync commit, (150,150) is green.
- Double buffer:
  - Stimulus: write slot 0 mid-frame at line 300.
  - Required response: the rest of the current frame is unchanged. The change appears from line 0 of the next frame. cmd_ready=0 for exactly the commit cycle.
- Degenerate and out-of-range:
  - Stimulus: slot with x0=50, x1=40; separately a command with cmd_index=N_RECTS.
  - Required response: the first never draws; the second is accepted (ready high) with no visible effect.
- Outline (RECT_OUTLINE_EN):
  - Stimulus: slot 0 = (10,10)-(14,14) outlined red.
  - Required response: (10,12) and (12,14) are red. (12,12) is bg.

Source files
------------

// File: rtl/rect_compositor.sv
// Rectangle compositor: double-buffered bank of filled rectangles drawn over a
// background colour, 2-cycle pipeline. Optional feature macro: RECT_OUTLINE_EN.
module rect_compositor #(
  parameter int N_RECTS  = 8,
  parameter int H_PIXELS = 800,
  parameter int V_PIXELS = 600,
  parameter int COORD_W  = 10
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [$clog2(N_RECTS)-1:0] cmd_index,
  input  logic [COORD_W-1:0]         cmd_x0,
  input  logic [COORD_W-1:0]         cmd_y0,
  input  logic [COORD_W-1:0]         cmd_x1,
  input  logic [COORD_W-1:0]         cmd_y1,
  input  logic [23:0]                cmd_color,
  input  logic                       cmd_enable,
`ifdef RECT_OUTLINE_EN
  input  logic                       cmd_outline,
`endif
  input  logic [23:0]                bg_color,
  input  logic                       in_hsync,
  input  logic                       in_vsync,
  input  logic                       in_draw_area,
  output logic                       out_hsync,
  output logic                       out_vsync,
  output logic                       out_draw_area,
  output logic [7:0]                 red,
  output logic [7:0]                 green,
  output logic [7:0]                 blue
);

  localparam logic [COORD_W-1:0] X_MAX = COORD_W'(H_PIXELS - 1);
  localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(V_PIXELS - 1);

  typedef struct packed {
    logic               enable;
    logic               outline;
    logic [COORD_W-1:0] x0;
    logic [COORD_W-1:0] y0;
    logic [COORD_W-1:0] x1;
    logic [COORD_W-1:0] y1;
    logic [23:0]        color;
  } rect_t;

  rect_t               shadow [N_RECTS];
  rect_t               active [N_RECTS];
  rect_t               cmd_rect;
  logic                ready_q;
  logic                commit_q;
  logic [2:0]          sync_d1;   // {hsync, vsync, draw_area}
  logic [2:0]          sync_d2;
  logic [COORD_W-1:0]  x;
  logic [COORD_W-1:0]  y;
  logic [N_RECTS-1:0]  in_box;
  logic [N_RECTS-1:0]  on_edge;
  logic [N_RECTS-1:0]  hit_d;
  logic [N_RECTS-1:0]  hit_q;
  logic [23:0]         color_d;
  logic [23:0]         rgb_q;
  logic                cmd_fire;
  logic                vsync_rise;
  logic                de_fall;

  assign vsync_rise = in_vsync & ~sync_d1[1];
  assign de_fall    = sync_d1[0] & ~in_draw_area;
  assign cmd_ready  = ready_q & ~commit_q;
  assign cmd_fire   = cmd_valid && cmd_ready && (int'(cmd_index) < N_RECTS);

  always_comb begin
    cmd_rect.enable = cmd_enable;
`ifdef RECT_OUTLINE_EN
    cmd_rect.outline = cmd_outline;
`else
    cmd_rect.outline = 1'b0;
`endif
    cmd_rect.x0    = cmd_x0;
    cmd_rect.y0    = cmd_y0;
    cmd_rect.x1    = cmd_x1;
    cmd_rect.y1    = cmd_y1;
    cmd_rect.color = cmd_color;
  end

  // NOTE: the slot banks are flops, not RAM, so they can and must be reset
  // explicitly; otherwise stale rectangles would survive a mid-frame reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_RECTS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      if (cmd_fire) shadow[cmd_index] <= cmd_rect;
      // Commit sees any write accepted in the cycle before it.
      if (commit_q) begin
        for (int i = 0; i < N_RECTS; i++) active[i] <= shadow[i];
      end
    end
  end

  // NOTE: all state updates use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q  <= 1'b0;
      commit_q <= 1'b0;
      sync_d1  <= '0;
      sync_d2  <= '0;
      x        <= '0;
      y        <= '0;
    end else begin
      ready_q  <= 1'b1;
      commit_q <= vsync_rise;
      sync_d1  <= {in_hsync, in_vsync, in_draw_area};
      sync_d2  <= sync_d1;
      if (vsync_rise) begin
        x <= '0;
        y <= '0;
      end else if (de_fall) begin
        x <= '0;
        if (y < Y_MAX) y <= y + 1'b1;
      end else if (in_draw_area && x < X_MAX) begin
        x <= x + 1'b1;
      end
    end
  end

  // NOTE: every combinational output gets a default first so no path through
  // the block leaves it unassigned and infers a latch.
  always_comb begin
    in_box  = '0;
    on_edge = '0;
    hit_d   = '0;
    for (int i = 0; i < N_RECTS; i++) begin
      in_box[i]  = (x >= active[i].x0) && (x <= active[i].x1) &&
                   (y >= active[i].y0) && (y <= active[i].y1);
      on_edge[i] = (x == active[i].x0) || (x == active[i].x1) ||
                   (y == active[i].y0) || (y == active[i].y1);
      hit_d[i]   = active[i].enable && in_box[i] &&
                   (!active[i].outline || on_edge[i]);
    end
  end

  // Walk from lowest priority upward so slot 0 wins.
  always_comb begin
    color_d = bg_color;
    for (int i = N_RECTS - 1; i >= 0; i--) begin
      if (hit_q[i]) color_d = active[i].color;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_q <= '0;
      rgb_q <= '0;
    end else begin
      hit_q <= hit_d;
      rgb_q <= sync_d1[0] ? color_d : 24'h0;
    end
  end

  assign out_hsync     = sync_d2[2];
  assign out_vsync     = sync_d2[1];
  assign out_draw_area = sync_d2[0];
  assign red           = rgb_q[23:16];
  assign green         = rgb_q[15:8];
  assign blue          = rgb_q[7:0];

endmodule
